// File: rtl/full_adder_unit.sv
// full_adder_unit: ripple-carry adder built from single-bit full-adder cells,
// with an optional output register so it can sit in a clocked datapath as a
// one-cycle pipeline stage. {carry, sum} = a + b + cin, with no result bits lost.

// full_adder: one ripple cell. The carry-out is generate | (propagate & carry-in).
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_p;
  logic w_g;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;
  assign o_s = w_p ^ i_c;
  assign o_c = w_g | (i_c & w_p);

endmodule

// Output handshake: there is no backpressure. valid=1 means sum/carry hold a
// result computed from inputs that were qualified by en=1. In registered mode,
// valid is en delayed by one rising edge. In combinational mode, valid is en
// itself. A consumer samples sum/carry whenever it sees valid=1.
module full_adder_unit #(
  parameter int unsigned WIDTH = 1,
  parameter bit          PIPE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             valid
);

  // w_c[i] is the carry into bit i; w_c[WIDTH] is the carry-out of the MSB.
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  assign w_c[0] = cin;

  // One full-adder cell per bit. The carry ripples from the LSB upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .i_a (a[i]),
      .i_b (b[i]),
      .i_c (w_c[i]),
      .o_s (w_s[i]),
      .o_c (w_c[i+1])
    );
  end

  if (PIPE) begin : g_pipe
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_valid;

    // Capture the result only on qualified cycles. valid tracks en every edge.
    // Reset clears everything immediately, which discards any pending result.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sum   <= '0;
        r_carry <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= en;
        if (en) begin
          r_sum   <= w_s;
          r_carry <= w_c[WIDTH];
        end
      end
    end

    assign sum   = r_sum;
    assign carry = r_carry;
    assign valid = r_valid;
  end else begin : g_comb
    // Purely combinational mode: clk and rst have no effect on the datapath.
    logic w_unused_clk_rst;

    assign w_unused_clk_rst = clk ^ rst;
    assign sum   = w_s;
    assign carry = w_c[WIDTH];
    assign valid = en;
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// tb_full_adder_unit: directed-vector bench for full_adder_unit. Four instances
// cover WIDTH=1 combinational, WIDTH=1 registered, WIDTH=8 registered and an
// exhaustive WIDTH=4 registered sweep. Stimulus pushes the expected result into
// a per-instance queue. A monitor per instance pops and compares on each
// falling edge where the instance presents valid=1.
module tb_full_adder_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=1, PIPE=0
  logic c_en, c_a, c_b, c_cin, c_sum, c_carry, c_valid;
  // WIDTH=1, PIPE=1
  logic p_en, p_a, p_b, p_cin, p_sum, p_carry, p_valid;
  // WIDTH=8, PIPE=1
  logic       w8_en, w8_cin, w8_carry, w8_valid;
  logic [7:0] w8_a, w8_b, w8_sum;
  // WIDTH=4, PIPE=1
  logic       w4_en, w4_cin, w4_carry, w4_valid;
  logic [3:0] w4_a, w4_b, w4_sum;

  full_adder_unit #(.WIDTH(1), .PIPE(1'b0)) u_c (
    .clk(clk), .rst(rst), .en(c_en), .a(c_a), .b(c_b), .cin(c_cin),
    .sum(c_sum), .carry(c_carry), .valid(c_valid)
  );
  full_adder_unit #(.WIDTH(1), .PIPE(1'b1)) u_p (
    .clk(clk), .rst(rst), .en(p_en), .a(p_a), .b(p_b), .cin(p_cin),
    .sum(p_sum), .carry(p_carry), .valid(p_valid)
  );
  full_adder_unit #(.WIDTH(8), .PIPE(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .en(w8_en), .a(w8_a), .b(w8_b), .cin(w8_cin),
    .sum(w8_sum), .carry(w8_carry), .valid(w8_valid)
  );
  full_adder_unit #(.WIDTH(4), .PIPE(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .en(w4_en), .a(w4_a), .b(w4_b), .cin(w4_cin),
    .sum(w4_sum), .carry(w4_carry), .valid(w4_valid)
  );

  // ---------------- scoreboard queues ----------------
  logic [1:0] c_exp_q[$];   // {sum, carry}
  logic [1:0] p_exp_q[$];   // {sum, carry}
  logic [8:0] w8_exp_q[$];  // {carry, sum}
  logic [4:0] w4_exp_q[$];  // {carry, sum}

  logic [1:0] c_e, p_e;
  logic [8:0] w8_e;
  logic [4:0] w4_e;

  // Hand-computed truth table for {a,b,cin} = 000..111, as {sum, carry}.
  logic [1:0] c_tab [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

  // Hand-computed WIDTH=8 vectors.
  logic [7:0] w8_ta [5] = '{8'hFF, 8'h7F, 8'h12, 8'hFF, 8'h00};
  logic [7:0] w8_tb [5] = '{8'h01, 8'h80, 8'h34, 8'hFF, 8'h00};
  logic       w8_tc [5] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
  logic [8:0] w8_tx [5] = '{9'h100, 9'h100, 9'h047, 9'h1FF, 9'h000};

  logic [8:0] vec;

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (c_valid === 1'b1) begin
      total++;
      if (c_exp_q.size() == 0) begin
        bad++;
        $display("FAIL c_unexpected: got sum,carry=%b%b with no expected entry", c_sum, c_carry);
      end else begin
        c_e = c_exp_q.pop_front();
        if ({c_sum, c_carry} !== c_e) begin
          bad++;
          $display("FAIL c_result: got sum,carry=%b%b expected %b", c_sum, c_carry, c_e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (p_valid === 1'b1) begin
      total++;
      if (p_exp_q.size() == 0) begin
        bad++;
        $display("FAIL p_unexpected: got sum,carry=%b%b with no expected entry", p_sum, p_carry);
      end else begin
        p_e = p_exp_q.pop_front();
        if ({p_sum, p_carry} !== p_e) begin
          bad++;
          $display("FAIL p_result: got sum,carry=%b%b expected %b", p_sum, p_carry, p_e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (w8_valid === 1'b1) begin
      total++;
      if (w8_exp_q.size() == 0) begin
        bad++;
        $display("FAIL w8_unexpected: got carry,sum=%b,%h with no expected entry", w8_carry, w8_sum);
      end else begin
        w8_e = w8_exp_q.pop_front();
        if ({w8_carry, w8_sum} !== w8_e) begin
          bad++;
          $display("FAIL w8_result: got carry,sum=%b,%h expected %b,%h", w8_carry, w8_sum, w8_e[8], w8_e[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (w4_valid === 1'b1) begin
      total++;
      if (w4_exp_q.size() == 0) begin
        bad++;
        $display("FAIL w4_unexpected: got carry,sum=%b,%h with no expected entry", w4_carry, w4_sum);
      end else begin
        w4_e = w4_exp_q.pop_front();
        if ({w4_carry, w4_sum} !== w4_e) begin
          bad++;
          $display("FAIL w4_result: got carry,sum=%b,%h expected %b,%h", w4_carry, w4_sum, w4_e[4], w4_e[3:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    c_en = 1'b0; c_a = 1'b0; c_b = 1'b0; c_cin = 1'b0;
    // Registered instance sees qualified all-ones input during reset; it must stay cleared.
    p_en = 1'b1; p_a = 1'b1; p_b = 1'b1; p_cin = 1'b1;
    w8_en = 1'b0; w8_a = '0; w8_b = '0; w8_cin = 1'b0;
    w4_en = 1'b0; w4_a = '0; w4_b = '0; w4_cin = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    check("rst_p_outputs", 16'({p_sum, p_carry, p_valid}), 16'h0);
    check("rst_w8_outputs", 16'({w8_carry, w8_sum, w8_valid}), 16'h0);
    check("rst_w4_outputs", 16'({w4_carry, w4_sum, w4_valid}), 16'h0);

    step();
    p_en = 1'b0; p_a = 1'b0; p_b = 1'b0; p_cin = 1'b0;
    rst = 1'b0;

    // WIDTH=1 combinational: walk the truth table, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      step();
      vec = 9'(i);
      {c_a, c_b, c_cin} = vec[2:0];
      c_en = 1'b1;
      c_exp_q.push_back(c_tab[i]);
    end
    step();
    c_en = 1'b0;

    // WIDTH=1 registered: latency and "earlier outputs unchanged".
    step();
    {p_a, p_b, p_cin} = 3'b000; p_en = 1'b1;
    p_exp_q.push_back(2'b00);
    step();
    {p_a, p_b, p_cin} = 3'b111; p_en = 1'b1;
    p_exp_q.push_back(2'b11);
    #2;
    check("p_before_edge", 16'({p_sum, p_carry, p_valid}), 16'b001);
    step();
    p_en = 1'b0;
    step();
    #1;
    check("p_hold_11", 16'({p_sum, p_carry, p_valid}), 16'b110);
    // Asynchronous reset pulse between edges clears outputs immediately.
    rst = 1'b1;
    #1;
    check("p_async_clear", 16'({p_sum, p_carry, p_valid}), 16'b000);
    rst = 1'b0;
    step();
    check("p_valid_after_rst", 16'({p_sum, p_carry, p_valid}), 16'b000);

    // Hold behaviour: capture 011, then present 100 with en=0.
    {p_a, p_b, p_cin} = 3'b011; p_en = 1'b1;
    p_exp_q.push_back(2'b01);
    step();
    {p_a, p_b, p_cin} = 3'b100; p_en = 1'b0;
    step();
    #1;
    check("p_hold_01", 16'({p_sum, p_carry, p_valid}), 16'b010);

    // WIDTH=8 registered: carry ripple and boundary vectors, back to back.
    for (int i = 0; i < 5; i++) begin
      step();
      w8_a = w8_ta[i]; w8_b = w8_tb[i]; w8_cin = w8_tc[i]; w8_en = 1'b1;
      w8_exp_q.push_back(w8_tx[i]);
    end
    step();
    w8_en = 1'b0;

    // WIDTH=4 registered: every input combination against a + b + cin.
    for (int v = 0; v < 512; v++) begin
      step();
      vec = 9'(v);
      {w4_a, w4_b, w4_cin} = vec;
      w4_en = 1'b1;
      w4_exp_q.push_back(5'(w4_a) + 5'(w4_b) + 5'(w4_cin));
    end
    step();
    w4_en = 1'b0;

    repeat (3) step();

    check("c_queue_drained", 16'(c_exp_q.size()), 16'h0);
    check("p_queue_drained", 16'(p_exp_q.size()), 16'h0);
    check("w8_queue_drained", 16'(w8_exp_q.size()), 16'h0);
    check("w4_queue_drained", 16'(w4_exp_q.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
